// File: rtl/fp16_to_fixed_if.sv
// Handshake bundle for fp16_to_fixed: operand in, fixed-point result plus flags out.
interface fp16_to_fixed_if #(
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
  logic             out_nan;
  logic             out_inexact;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_nan, out_inexact
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_nan, out_inexact
  );
endinterface

// File: rtl/fp16_to_fixed.sv
// Iterative binary16 -> signed Q fixed-point converter, one alignment bit per clock.
// Optional FP16_FIX_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module fp16_to_fixed #(
  parameter int OUT_W  = 16,
  parameter int FRAC_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  fp16_to_fixed_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

  localparam int MW = OUT_W + 1;
  localparam logic [MW:0]      LIM_POS = {2'b00, 1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [MW:0]      LIM_NEG = {2'b00, 1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [MW-1:0]    mag_q, mag_d;
  logic             guard_q, guard_d;
  logic             sticky_q, sticky_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             sign_q, sign_d;
  logic             psat_q, psat_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;
  logic             out_nan_q, out_nan_d;
  logic             out_inexact_q, out_inexact_d;

  logic [4:0]        exp_in, exp_eff;
  logic [9:0]        frac_in;
  logic [10:0]       m_in;
  logic signed [7:0] sh;
  logic [7:0]        sh_abs;
  logic [5:0]        cnt_in;
  logic              inc;
  logic [MW:0]       mag_r;

  assign exp_in  = bus.in_data[14:10];
  assign frac_in = bus.in_data[9:0];
  assign m_in    = {exp_in != 5'd0, frac_in};
  assign exp_eff = (exp_in == 5'd0) ? 5'd1 : exp_in;
  assign sh      = $signed({3'b000, exp_eff}) - 8'sd25 + $signed(8'(FRAC_W));
  assign sh_abs  = sh[7] ? 8'(-sh) : 8'(sh);
  // Right shifts past 13 only feed sticky, so the count is capped there.
  assign cnt_in  = sh[7] ? ((sh_abs > 8'd13) ? 6'd13 : sh_abs[5:0])
                         : ((sh_abs > 8'(OUT_W)) ? 6'(OUT_W) : sh_abs[5:0]);

`ifdef FP16_FIX_ROUND_NEAREST_EN
  assign inc = guard_q & (sticky_q | mag_q[0]);
`else
  assign inc = 1'b0;
`endif
  assign mag_r = {1'b0, mag_q} + {{MW{1'b0}}, inc};

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_sat     = out_sat_q;
  assign bus.out_nan     = out_nan_q;
  assign bus.out_inexact = out_inexact_q;

  always_comb begin
    state_d       = state_q;
    mag_d         = mag_q;
    guard_d       = guard_q;
    sticky_d      = sticky_q;
    cnt_d         = cnt_q;
    left_d        = left_q;
    sign_d        = sign_q;
    psat_d        = psat_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_sat_d     = out_sat_q;
    out_nan_d     = out_nan_q;
    out_inexact_d = out_inexact_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d   = bus.in_data[15];
          mag_d    = MW'(m_in);
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          psat_d   = 1'b0;
          left_d   = ~sh[7];
          cnt_d    = cnt_in;
          if (exp_in == 5'd31 || (exp_in == 5'd0 && frac_in == 10'd0)) begin
            state_d       = DONE;
            out_valid_d   = 1'b1;
            out_inexact_d = 1'b0;
            out_nan_d     = (exp_in == 5'd31) && (frac_in != 10'd0);
            out_sat_d     = (exp_in == 5'd31) && (frac_in == 10'd0);
            out_data_d    = '0;
            if ((exp_in == 5'd31) && (frac_in == 10'd0))
              out_data_d = bus.in_data[15] ? OUT_MIN : OUT_MAX;
          end else begin
            state_d = (cnt_in == 6'd0) ? ROUND : ALIGN;
          end
        end
      end
      ALIGN: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = ROUND;
        if (left_q) begin
          mag_d = {mag_q[MW-2:0], 1'b0};
          // A one reaching the top bit is already out of range: stop early.
          if (mag_q[MW-2]) begin
            psat_d  = 1'b1;
            state_d = ROUND;
          end
        end else begin
          mag_d    = {1'b0, mag_q[MW-1:1]};
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
        end
      end
      ROUND: begin
        state_d       = DONE;
        out_valid_d   = 1'b1;
        out_nan_d     = 1'b0;
        out_inexact_d = guard_q | sticky_q;
        if (psat_q || (mag_r > (sign_q ? LIM_NEG : LIM_POS))) begin
          out_sat_d  = 1'b1;
          out_data_d = sign_q ? OUT_MIN : OUT_MAX;
        end else begin
          out_sat_d  = 1'b0;
          out_data_d = sign_q ? -mag_r[OUT_W-1:0] : mag_r[OUT_W-1:0];
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mag_q         <= '0;
      guard_q       <= 1'b0;
      sticky_q      <= 1'b0;
      cnt_q         <= '0;
      left_q        <= 1'b0;
      sign_q        <= 1'b0;
      psat_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sat_q     <= 1'b0;
      out_nan_q     <= 1'b0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mag_q         <= mag_d;
      guard_q       <= guard_d;
      sticky_q      <= sticky_d;
      cnt_q         <= cnt_d;
      left_q        <= left_d;
      sign_q        <= sign_d;
      psat_q        <= psat_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sat_q     <= out_sat_d;
      out_nan_q     <= out_nan_d;
      out_inexact_q <= out_inexact_d;
    end
  end
endmodule

// File: tb/tb_fp16_to_fixed.sv
// Scoreboard bench for fp16_to_fixed: arithmetic reference model, random and directed operands.
module tb_fp16_to_fixed;
  localparam int OUT_W  = 16;
  localparam int FRAC_W = 8;
  localparam logic [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp16_to_fixed_if #(.OUT_W(OUT_W)) bus ();
  fp16_to_fixed #(.OUT_W(OUT_W), .FRAC_W(FRAC_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    logic [OUT_W-1:0] data;
    bit               sat;
    bit               nan;
    bit               inex;
    int               lat;
    int               acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
  endtask

  // Value = (-1)^s * M * 2^sh computed directly, then rounded and clamped.
  function automatic exp_t model(input logic [15:0] x);
    exp_t   r;
    int     e, f, ee, sh, d, n;
    bit     s, hit;
    longint m, mag, q, rem, half, lp, ln;
    s = x[15]; e = int'(x[14:10]); f = int'(x[9:0]);
    r.data = '0; r.sat = 0; r.nan = 0; r.inex = 0; r.lat = 1; r.acc = 0;
    if (e == 31) begin
      if (f != 0) r.nan = 1;
      else begin r.sat = 1; r.data = s ? OMIN : OMAX; end
      return r;
    end
    if (e == 0 && f == 0) return r;
    m  = (e == 0) ? longint'(f) : longint'(1024 + f);
    ee = (e == 0) ? 1 : e;
    sh = ee - 25 + FRAC_W;
    if (sh >= 0) begin
      mag = m << sh;
      n = (sh > OUT_W) ? OUT_W : sh;
      hit = 0;
      for (int k = 1; k <= n; k++)
        if (!hit && ((m << k) >= (64'sd1 << OUT_W))) begin n = k; hit = 1; end
    end else begin
      d   = -sh;
      q   = m >> d;
      rem = m - (q << d);
      r.inex = (rem != 0);
      half = 64'sd1 << (d - 1);
`ifdef FP16_FIX_ROUND_NEAREST_EN
      if (rem > half || (rem == half && q[0])) q = q + 1;
`else
      if (half < 0) q = 0;
`endif
      mag = q;
      n = (d > 13) ? 13 : d;
    end
    r.lat = 2 + n;
    lp = (64'sd1 << (OUT_W-1)) - 1;
    ln = 64'sd1 << (OUT_W-1);
    if (s) begin
      if (mag > ln) begin r.sat = 1; r.data = OMIN; end
      else r.data = OUT_W'(-mag);
    end else begin
      if (mag > lp) begin r.sat = 1; r.data = OMAX; end
      else r.data = OUT_W'(mag);
    end
    return r;
  endfunction

  task automatic send(input logic [15:0] x, input bit track);
    exp_t e;
    int   w;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    w = 0;
    while (!bus.in_ready && w < 300) begin @(negedge clk); w++; end
    if (w >= 300) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    e = model(x);
    e.acc = cyc;
    if (track) sb.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || bus.out_valid) && w < 1000) begin @(negedge clk); w++; end
    if (w >= 1000) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (stall > 0) begin
        bus.out_ready = 1'b0;
        if (bus.out_valid) stall--;
      end else begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    exp_t cur;
    bit   seen;
    seen = 0;
    cur.data = '0; cur.sat = 0; cur.nan = 0; cur.inex = 0; cur.lat = 0; cur.acc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
      end else if (bus.out_valid) begin
        if (!seen) begin
          if (sb.size() == 0) chk("unexpected_output", 1, 0);
          else begin
            cur = sb.pop_front();
            chk("out_data", bus.out_data, cur.data);
            chk("out_sat", bus.out_sat, cur.sat);
            chk("out_nan", bus.out_nan, cur.nan);
            chk("out_inexact", bus.out_inexact, cur.inex);
            chk("latency", cyc - cur.acc, cur.lat);
          end
          seen = 1;
        end else begin
          chk("hold_data", bus.out_data, cur.data);
          chk("hold_sat", bus.out_sat, cur.sat);
        end
        chk("in_ready_busy", bus.in_ready, 0);
        if (bus.out_ready) seen = 0;
      end
    end
  end

  logic [15:0] dir_vec [13];

  initial begin
    logic [15:0] x;
    dir_vec = '{16'h3C00, 16'hC100, 16'h3C03, 16'hD800, 16'h5800, 16'h7BFF, 16'h7C00,
                16'h7E00, 16'hFC00, 16'h8000, 16'h0000, 16'h0001, 16'h8400};
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_flags", {bus.out_sat, bus.out_nan, bus.out_inexact}, 0);

    for (int i = 0; i < 13; i++) begin
      if (dir_vec[i] == 16'h3C03) stall = 5;
      send(dir_vec[i], 1'b1);
    end
    for (int i = 0; i < 300; i++) begin
      x = 16'($urandom);
      if (i % 4 == 0) x[14:10] = 5'($urandom_range(10, 22));
      send(x, 1'b1);
    end
    drain();

    send(16'h0001, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_out_data", bus.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h3C00, 1'b1);
    drain();
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fp16_to_fixed.md
# fp16_to_fixed

Iterative converter from IEEE-754 half-precision (binary16) to signed two's-complement fixed point. It sits at the output boundary of the FFT datapath, after the half-precision adder/butterfly stage. It turns float results back into fixed-point samples for downstream consumers. Alignment is done one bit per clock by a small state machine. Input and output use valid/ready handshakes.

## Interface
- `OUT_W`, default 16: output width in bits, range 12..32.
- `FRAC_W`, default 8: fractional bits of the output; output is Q(OUT_W-FRAC_W-1).FRAC_W. Range 0..OUT_W-1.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept an input; high only in IDLE.
- `in_data`  in  16  binary16 operand: sign[15], exponent[14:10], fraction[9:0].
- `out_valid`  out  1  result is valid; held until accepted.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  OUT_W  signed fixed-point result.
- `out_sat`  out  1  result was clamped (overflow or infinity).
- `out_nan`  out  1  input was NaN.
- `out_inexact`  out  1  nonzero bits were discarded by right alignment.

## Operation
- **Decode.**
  - Normal inputs: E = exp, M = {1, frac}.
  - Denormal inputs: E = 1, M = {0, frac}.
  - Shift amount: sh = E - 25 + FRAC_W, signed.
  - Value: (-1)^s × M × 2^sh in output LSBs.
- **States:** IDLE, ALIGN, ROUND, DONE.
- **IDLE.**
  - On `in_valid && in_ready`, capture the operand.
  - Load a magnitude register with OUT_W+1 bits plus guard and sticky bits. Load M unshifted.
  - Load the counter with |sh|, capped: left shifts at OUT_W, right shifts at 13.
  - Special inputs go directly to DONE with the final result:
    - exp=0 and frac=0: result 0, no flags.
    - exp=31 and frac=0 (infinity): saturate by sign, `out_sat` set.
    - exp=31 and frac≠0 (NaN): result 0, `out_nan` set, `out_sat` clear.
  - If the counter is 0, go to ROUND. Otherwise go to ALIGN.
- **ALIGN.**
  - Shift one bit per cycle in the direction given by sign(sh), and decrement the counter.
  - Right shifts move the LSB into guard; the old guard ORs into sticky.
  - On a left shift, if a 1 reaches bit OUT_W of the magnitude, set the pending-saturation flag and go to ROUND immediately. This is early termination.
  - Go to ROUND when the counter reaches 0.
- **ROUND.**
  - Apply the rounding mode described under Configuration.
  - Check the range:
    - Positive results with magnitude > 2^(OUT_W-1)-1 clamp to 2^(OUT_W-1)-1.
    - Negative results with magnitude > 2^(OUT_W-1) clamp to -2^(OUT_W-1).
    - A negative magnitude of exactly 2^(OUT_W-1) is legal and is not clamped.
  - Apply the sign by two's complement. Register `out_data` and flags, then go to DONE.
  - `out_inexact` = guard | sticky.
- **DONE.**
  - `out_valid`=1; outputs are held stable.
  - On `out_ready`, go to IDLE.
  - A new input is accepted no earlier than the cycle after the handshake.
- Negative zero produces 0. Rounding that carries past the range saturates.

## Timing
- **Reset values:**
  - State IDLE, so `in_ready`=1.
  - `out_valid`=0 and `out_data`=0.
  - `out_sat`=0, `out_nan`=0, `out_inexact`=0.
- `in_ready` is decoded combinationally from state only.
- `out_*` are registered.
- **Latency:** from the accept edge to `out_valid` high:
  - Special inputs: 1 cycle.
  - All other inputs: 2 + n cycles, where n is the number of ALIGN cycles.
  - n = capped |sh|. For left shifts, n is lower if early saturation triggers.
- **Throughput:** at most one conversion in flight. The next accept happens in IDLE, one cycle after the output handshake.
- `out_valid` with `out_ready` held high: `out_valid` is high for exactly one cycle.
- **Reset mid-operation:** asserting `rst_n` in any state aborts the conversion immediately. The in-flight result is discarded and all outputs return to reset values.

## Configuration
- `FP16_FIX_ROUND_NEAREST_EN`
  - **Defined:** round to nearest, ties to even, using the guard bit and sticky OR LSB. Rounding adds one ROUND-stage increment and never adds a cycle.
  - **Undefined:** truncate magnitude, i.e. round toward zero. Guard and sticky feed only `out_inexact`.

## Test plan
Defaults: OUT_W=16, FRAC_W=8.
- 1.0 (`0x3C00`): sh=-2 → `out_data`=`0x0100`, no flags, `out_valid` 4 cycles after accept.
- -2.5 (`0xC100`): sh=-1 → `0xFD80`, no flags.
- 1.0029296875 (`0x3C03`): with macro `0x0101`; without macro `0x0100`. `out_inexact`=1 in both cases.
- Saturation:
  - -128.0 (`0xD800`) → `0x8000`, `out_sat`=0.
  - +128.0 (`0x5800`) → `0x7FFF`, `out_sat`=1.
  - 65504 (`0x7BFF`) → `0x7FFF`, `out_sat`=1.
- Specials:
  - +Inf (`0x7C00`) → `0x7FFF`, `out_sat`=1, latency 1.
  - NaN (`0x7E00`) → `0x0000`, `out_nan`=1, latency 1.
- Handshake and reset:
  - Hold `out_ready`=0 for 5 cycles: output stays stable and `in_ready` stays 0.
  - Pulse `rst_n` low during ALIGN: `out_valid`=0 and `in_ready`=1 immediately. The next conversion of `0x3C00` still yields `0x0100`.
